ifu_itcm_stub: RTL and testbench

Parametrised instruction-memory responder that sits on the IFU fetch interface (`ifu_req_*` / `ifu_rsp_*`) in place of the real ITCM. Its purpose is to exercise `cpu_top` and `ifu_ifetch` under controlled conditions:

- configurable response latency;
- multiple outstanding fetches;
- periodic request back-pressure;
- optional error reporting.

Memory is preloaded through a write port before or during reset release. It is synthesizable, so the same stub serves RTL simulation and FPGA bring-up.

---
 rtl/ifu_itcm_stub.sv | 168 ++++++++++++++++
 tb/tb_ifu_itcm_stub.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_itcm_stub.sv
// Synthesizable ITCM stand-in for the IFU fetch port: fixed-latency pipeline,
// in-order response FIFO, optional ready stalls. Define ITCM_STUB_ERR_EN for error responses.
module ifu_itcm_stub #(
  parameter int unsigned PC_SIZE      = 32,
  parameter int unsigned INSTR_SIZE   = 32,
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned OUTSTANDING  = 2,
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [PC_SIZE-1:0]    ifu_req_pc,
  output logic                  ifu_rsp_valid,
  input  logic                  ifu_rsp_ready,
  output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  ifu_rsp_err,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [INSTR_SIZE-1:0] load_data,
  output logic [15:0]           req_cnt,
  output logic [15:0]           rsp_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CW    = $clog2(OUTSTANDING + 1);
  localparam int unsigned IW    = $clog2(LATENCY + 1);

  logic [INSTR_SIZE-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  req_err;
  logic [INSTR_SIZE-1:0] req_instr;

  logic [LATENCY-1:0]    pipe_v;
  logic [INSTR_SIZE-1:0] pipe_i [LATENCY];
  logic                  pipe_e [LATENCY];

  logic [INSTR_SIZE-1:0] fifo_i [OUTSTANDING];
  logic                  fifo_e [OUTSTANDING];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         fifo_count;

  logic [IW-1:0]         inflight;
  logic [3:0]            occupancy;
  logic                  stall;
  logic                  accept;
  logic                  push;
  logic                  pop;

  assign word_idx = ifu_req_pc[DEPTH_LOG2+1:2];

`ifdef ITCM_STUB_ERR_EN
  always_comb begin
    req_err   = (ifu_req_pc[1:0] != 2'b00) || ((ifu_req_pc >> (DEPTH_LOG2 + 2)) != '0);
    req_instr = req_err ? '0 : mem[word_idx];
  end
`else
  // Byte offset and high address bits are deliberately ignored: addresses alias.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{ifu_req_pc[1:0], ifu_req_pc[PC_SIZE-1:DEPTH_LOG2+2]};

  always_comb begin
    req_err   = 1'b0;
    req_instr = mem[word_idx];
  end
`endif

  generate
    if (STALL_PERIOD != 0) begin : g_stall
      localparam int unsigned SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      logic [SW-1:0] stall_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stall_cnt <= '0;
        end else if (stall_cnt == SW'(STALL_PERIOD - 1)) begin
          stall_cnt <= '0;
        end else begin
          stall_cnt <= stall_cnt + SW'(1);
        end
      end

      assign stall = (stall_cnt == SW'(STALL_PERIOD - 1));
    end else begin : g_no_stall
      assign stall = 1'b0;
    end
  endgenerate

  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      inflight = inflight + IW'(pipe_v[k]);
    end
  end

  // Occupancy uses registered state only, so a pop frees a slot one cycle later.
  assign occupancy     = 4'(inflight) + 4'(fifo_count);
  assign ifu_req_ready = rst_n && !load_en && !stall && (occupancy < 4'(OUTSTANDING));

  assign accept = ifu_req_valid && ifu_req_ready;
  assign push   = pipe_v[LATENCY-1];
  assign pop    = (fifo_count != '0) && ifu_rsp_ready;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v     <= '0;
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      req_cnt    <= '0;
      rsp_cnt    <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) begin
        pipe_i[k] <= '0;
        pipe_e[k] <= 1'b0;
      end
      for (int unsigned k = 0; k < OUTSTANDING; k++) begin
        fifo_i[k] <= '0;
        fifo_e[k] <= 1'b0;
      end
    end else begin
      pipe_v[0] <= accept;
      pipe_i[0] <= req_instr;
      pipe_e[0] <= req_err;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_i[k] <= pipe_i[k-1];
        pipe_e[k] <= pipe_e[k-1];
      end

      if (push) begin
        fifo_i[tail] <= pipe_i[LATENCY-1];
        fifo_e[tail] <= pipe_e[LATENCY-1];
        tail         <= ptr_next(tail);
      end
      if (pop) begin
        head <= ptr_next(head);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);

      if (accept) begin
        req_cnt <= req_cnt + 16'd1;
      end
      if (pop) begin
        rsp_cnt <= rsp_cnt + 16'd1;
      end
    end
  end

  assign ifu_rsp_valid = (fifo_count != '0);
  assign ifu_rsp_instr = ifu_rsp_valid ? fifo_i[head] : '0;
  assign ifu_rsp_err   = ifu_rsp_valid && fifo_e[head];

endmodule

// File: tb/tb_ifu_itcm_stub.sv
// Directed bench for ifu_itcm_stub: three instances cover latency/ordering,
// outstanding limit with mid-flight reset, and periodic ready stalls.
module tb_ifu_itcm_stub;

  localparam logic [31:0] W0  = 32'h0010_0093;
  localparam logic [31:0] W1  = 32'h0020_8113;
  localparam logic [31:0] WB0 = 32'hA5A5_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        rst_a, req_valid_a, ready_a, rsp_valid_a, rsp_ready_a, err_a, load_en_a;
  logic [31:0] pc_a, instr_a, load_data_a;
  logic [9:0]  load_addr_a;
  logic [15:0] req_cnt_a, rsp_cnt_a;

  logic        rst_b, req_valid_b, ready_b, rsp_valid_b, rsp_ready_b, err_b, load_en_b;
  logic [31:0] pc_b, instr_b, load_data_b;
  logic [9:0]  load_addr_b;
  logic [15:0] req_cnt_b, rsp_cnt_b;

  logic        rst_c, req_valid_c, ready_c, rsp_valid_c, rsp_ready_c, err_c, load_en_c;
  logic [31:0] pc_c, instr_c, load_data_c;
  logic [9:0]  load_addr_c;
  logic [15:0] req_cnt_c, rsp_cnt_c;

  ifu_itcm_stub #(.LATENCY(1), .OUTSTANDING(2), .STALL_PERIOD(0)) dut_a (
    .clk(clk), .rst_n(rst_a),
    .ifu_req_valid(req_valid_a), .ifu_req_ready(ready_a), .ifu_req_pc(pc_a),
    .ifu_rsp_valid(rsp_valid_a), .ifu_rsp_ready(rsp_ready_a),
    .ifu_rsp_instr(instr_a), .ifu_rsp_err(err_a),
    .load_en(load_en_a), .load_addr(load_addr_a), .load_data(load_data_a),
    .req_cnt(req_cnt_a), .rsp_cnt(rsp_cnt_a)
  );

  ifu_itcm_stub #(.LATENCY(3), .OUTSTANDING(2), .STALL_PERIOD(0)) dut_b (
    .clk(clk), .rst_n(rst_b),
    .ifu_req_valid(req_valid_b), .ifu_req_ready(ready_b), .ifu_req_pc(pc_b),
    .ifu_rsp_valid(rsp_valid_b), .ifu_rsp_ready(rsp_ready_b),
    .ifu_rsp_instr(instr_b), .ifu_rsp_err(err_b),
    .load_en(load_en_b), .load_addr(load_addr_b), .load_data(load_data_b),
    .req_cnt(req_cnt_b), .rsp_cnt(rsp_cnt_b)
  );

  ifu_itcm_stub #(.LATENCY(1), .OUTSTANDING(4), .STALL_PERIOD(4)) dut_c (
    .clk(clk), .rst_n(rst_c),
    .ifu_req_valid(req_valid_c), .ifu_req_ready(ready_c), .ifu_req_pc(pc_c),
    .ifu_rsp_valid(rsp_valid_c), .ifu_rsp_ready(rsp_ready_c),
    .ifu_rsp_instr(instr_c), .ifu_rsp_err(err_c),
    .load_en(load_en_c), .load_addr(load_addr_c), .load_data(load_data_c),
    .req_cnt(req_cnt_c), .rsp_cnt(rsp_cnt_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Single fetch on instance a with rsp_ready held high.
  task automatic fetch_a(input logic [31:0] pc, input logic [31:0] exp_instr,
                         input logic exp_err, input string tag);
    int unsigned n;
    @(negedge clk);
    req_valid_a = 1'b1; pc_a = pc; rsp_ready_a = 1'b1;
    #1 check({tag, "_ready"}, ready_a, 1);
    @(negedge clk);
    req_valid_a = 1'b0;
    n = 0;
    while (!rsp_valid_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, rsp_valid_a, 1);
    check({tag, "_instr"}, instr_a, exp_instr);
    check({tag, "_err"}, err_a, exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned seen;
    int unsigned acc;
    logic        low_ok;
    logic [11:0] rdy_vec;

    rst_a = 0; req_valid_a = 0; pc_a = '0; rsp_ready_a = 0; load_en_a = 0; load_addr_a = '0; load_data_a = '0;
    rst_b = 0; req_valid_b = 0; pc_b = '0; rsp_ready_b = 0; load_en_b = 0; load_addr_b = '0; load_data_b = '0;
    rst_c = 0; req_valid_c = 0; pc_c = '0; rsp_ready_c = 0; load_en_c = 0; load_addr_c = '0; load_data_c = '0;

    // Preload during reset
    @(negedge clk);
    load_en_a = 1; load_addr_a = 10'd0; load_data_a = W0;
    load_en_b = 1; load_addr_b = 10'd0; load_data_b = WB0;
    load_en_c = 1; load_addr_c = 10'd0; load_data_c = 32'h0000_0013;
    @(negedge clk);
    load_addr_a = 10'd1; load_data_a = W1;
    load_en_b = 0; load_en_c = 0;
    @(negedge clk);
    load_en_a = 0;
    #1;
    check("rst_ready", ready_a, 0);
    check("rst_rsp_valid", rsp_valid_a, 0);
    check("rst_instr", instr_a, 0);
    check("rst_err", err_a, 0);
    check("rst_req_cnt", req_cnt_a, 0);
    check("rst_rsp_cnt", rsp_cnt_a, 0);

    // Back-to-back fetch, LATENCY=1
    @(negedge clk);
    rst_a = 1; req_valid_a = 1; pc_a = 32'h0; rsp_ready_a = 1;
    #1 check("b2b_ready0", ready_a, 1);
    @(negedge clk);
    pc_a = 32'h4;
    #1 check("b2b_ready1", ready_a, 1);
    check("b2b_not_yet", rsp_valid_a, 0);
    @(negedge clk);
    req_valid_a = 0;
    #1 check("b2b_v0", rsp_valid_a, 1);
    check("b2b_i0", instr_a, W0);
    @(negedge clk);
    #1 check("b2b_v1", rsp_valid_a, 1);
    check("b2b_i1", instr_a, W1);
    @(negedge clk);
    #1 check("b2b_drained", rsp_valid_a, 0);
    check("b2b_req_cnt", req_cnt_a, 2);
    check("b2b_rsp_cnt", rsp_cnt_a, 2);

    // Error classification / aliasing
`ifdef ITCM_STUB_ERR_EN
    fetch_a(32'h0000_0002, 32'h0, 1'b1, "err_misalign");
    fetch_a(32'h0000_1000, 32'h0, 1'b1, "err_range");
`else
    fetch_a(32'h0000_0002, W0, 1'b0, "alias_misalign");
    fetch_a(32'h0000_1000, W0, 1'b0, "alias_range");
`endif
    fetch_a(32'h0000_0004, W1, 1'b0, "plain_w1");

    // Preload during traffic: pending response keeps old data
    @(negedge clk);
    req_valid_a = 1; pc_a = 32'h4; rsp_ready_a = 0;
    #1 check("load_pre_ready", ready_a, 1);
    @(negedge clk);
    req_valid_a = 0; load_en_a = 1; load_addr_a = 10'd1; load_data_a = 32'h0000_0013;
    #1 check("load_ready0", ready_a, 0);
    @(negedge clk);
    load_addr_a = 10'd2; load_data_a = 32'h1234_5678;
    #1 check("load_ready1", ready_a, 0);
    check("load_pend_valid", rsp_valid_a, 1);
    check("load_old_data", instr_a, W1);
    @(negedge clk);
    load_en_a = 0;
    #1 check("load_hold", instr_a, W1);
    check("load_ready_back", ready_a, 1);
    rsp_ready_a = 1;
    fetch_a(32'h0000_0004, 32'h0000_0013, 1'b0, "load_new_w1");
    fetch_a(32'h0000_0008, 32'h1234_5678, 1'b0, "load_new_w2");

    // Outstanding limit, LATENCY=3, OUTSTANDING=2
    @(negedge clk);
    rst_b = 1; req_valid_b = 1; pc_b = 32'h0; rsp_ready_b = 0;
    #1 check("os_ready0", ready_b, 1);
    @(negedge clk);
    #1 check("os_ready1", ready_b, 1);
    @(negedge clk);
    #1 check("os_full", ready_b, 0);
    low_ok = 1; n = 0;
    while (!rsp_valid_b && n < 10) begin
      if (ready_b) low_ok = 0;
      @(negedge clk);
      n++;
    end
    check("os_first_rsp_wait", n, 2);
    check("os_low_until_rsp", low_ok, 1);
    check("os_still_low", ready_b, 0);
    check("os_instr", instr_b, WB0);
    rsp_ready_b = 1;
    @(negedge clk);
    #1 check("os_ready_after_pop", ready_b, 1);
    check("os_rsp_cnt1", rsp_cnt_b, 1);
    check("os_req_cnt2", req_cnt_b, 2);
    @(negedge clk);
    req_valid_b = 0;
    #1 check("os_third_accepted", req_cnt_b, 3);
    n = 0;
    while (rsp_cnt_b != 16'd3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("os_drain", rsp_cnt_b, 3);

    // Reset mid-flight
    @(negedge clk);
    req_valid_b = 1; pc_b = 32'h0; rsp_ready_b = 1;
    @(negedge clk);
    @(negedge clk);
    req_valid_b = 0;
    rst_b = 0;
    #1 check("midrst_req_cnt", req_cnt_b, 0);
    check("midrst_valid", rsp_valid_b, 0);
    @(negedge clk);
    rst_b = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid_b) seen++;
    end
    check("midrst_no_rsp", seen, 0);
    check("midrst_rsp_cnt", rsp_cnt_b, 0);
    @(negedge clk);
    req_valid_b = 1; pc_b = 32'h0;
    #1 check("midrst_ready", ready_b, 1);
    @(negedge clk);
    req_valid_b = 0;
    n = 0;
    while (!rsp_valid_b && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("midrst_mem_valid", rsp_valid_b, 1);
    check("midrst_mem_kept", instr_b, WB0);

    // Periodic stall, STALL_PERIOD=4
    @(negedge clk);
    rst_c = 1; req_valid_c = 1; pc_c = 32'h0; rsp_ready_c = 1;
    acc = 0; rdy_vec = '0;
    for (int i = 0; i < 12; i++) begin
      #1;
      rdy_vec[i] = ready_c;
      if (ready_c) acc++;
      @(negedge clk);
    end
    req_valid_c = 0;
    check("stall_pattern", rdy_vec, 12'h777);
    check("stall_accepts", acc, 9);
    check("stall_req_cnt", req_cnt_c, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
